// File: rtl/axis_test_pkg.sv
// axis_test_pkg: definitions shared by the AXIS test traffic generator and checker
package axis_test_pkg;
    localparam int ERR_DATA = 0;
    localparam int ERR_KEEP = 1;
    localparam int ERR_LEN  = 2;
    localparam int ERR_OVS  = 3;
    localparam int BEAT_W   = 16;
    localparam logic [7:0][7:0] LAST_KEEP = {8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};
    typedef enum logic {S_FIRST, S_BODY} state_t;
    typedef logic [BEAT_W-1:0] beat_idx_t;
    function automatic logic keep_legal(input logic [7:0] k);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 8; i++) r = r | (k == LAST_KEEP[i]);
        return r;
    endfunction
    function automatic logic [3:0] keep_bytes(input logic [7:0] k);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = r + {3'd0, k[i]};
        return r;
    endfunction
    function automatic logic [63:0] beat_pattern(input beat_idx_t n);
        return {4{n}};
    endfunction
endpackage

// File: rtl/axis_test_checker_if.sv
// axis_test_checker_if: 64-bit AXI-Stream test packet bus
interface axis_test_checker_if;
    logic [63:0] tdata;
    logic [31:0] tuser;
    logic [7:0]  tkeep;
    logic        tlast;
    logic        tvalid;
    logic        tready;
    modport master (output tdata, tuser, tkeep, tlast, tvalid, input tready);
    modport slave (input tdata, tuser, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_ready_lfsr.sv
// axis_ready_lfsr: registered tready, optionally throttled by an x^8+x^6+x^5+x^4+1 LFSR
module axis_ready_lfsr #(
    parameter bit         P_BP_EN     = 1'b0,
    parameter logic [7:0] P_LFSR_SEED = 8'hA5
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic ready
);
    logic [7:0] lfsr;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lfsr  <= P_LFSR_SEED;
            ready <= 1'b0;
        end else begin
            lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            ready <= P_BP_EN ? lfsr[0] : 1'b1;
        end
    end
endmodule

// File: rtl/axis_test_checker.sv
// axis_test_checker: checks incrementing-pattern AXIS test packets and keeps result statistics
module axis_test_checker
    import axis_test_pkg::*;
#(
    parameter logic [15:0] P_MAX_BEATS = 16'd1024,
    parameter bit          P_BP_EN     = 1'b0,
    parameter logic [7:0]  P_LFSR_SEED = 8'hA5
) (
    input  logic                i_clk,
    input  logic                i_rst,
    axis_test_checker_if.slave  s_axis,
    output logic                pkt_done,
    output logic                pkt_ok,
    output logic [15:0]         pkt_len,
    output logic [31:0]         pkt_cnt,
    output logic [31:0]         err_cnt,
    output logic [3:0]          err_flags
);
    state_t      state, state_nxt;
    beat_idx_t   n, cur_n;
    logic [15:0] claimed, claim, meas_len;
    logic [3:0]  perr, prev, pkt_err;
    logic [7:0]  byte_en;
    logic [63:0] pat;
    logic        first, acc, data_bad;

    assign acc = s_axis.tvalid & s_axis.tready;

    axis_ready_lfsr #(.P_BP_EN(P_BP_EN), .P_LFSR_SEED(P_LFSR_SEED)) u_ready (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .ready(s_axis.tready)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_FIRST;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = acc ? (s_axis.tlast ? S_FIRST : S_BODY) : state;
    end

    // once oversize is flagged, n saturates and only the length check stays active
    always_comb begin
        first    = state == S_FIRST;
        cur_n    = first ? beat_idx_t'(1) : (n == P_MAX_BEATS ? n : n + 16'd1);
        claim    = first ? s_axis.tuser[15:0] : claimed;
        prev     = first ? 4'b0 : perr;
        byte_en  = s_axis.tlast ? s_axis.tkeep : 8'hFF;
        pat      = beat_pattern(cur_n);
        data_bad = 1'b0;
        for (int i = 0; i < 8; i++)
            data_bad = data_bad | (byte_en[i] & (s_axis.tdata[8*i +: 8] != pat[8*i +: 8]));
        meas_len = ((cur_n - 16'd1) << 3) + {12'd0, keep_bytes(s_axis.tkeep)};
        pkt_err  = prev;
        pkt_err[ERR_DATA] = prev[ERR_DATA] | (data_bad & ~prev[ERR_OVS]);
        pkt_err[ERR_KEEP] = prev[ERR_KEEP] | (~prev[ERR_OVS] &
                            (s_axis.tlast ? ~keep_legal(s_axis.tkeep) : s_axis.tkeep != 8'hFF));
        pkt_err[ERR_LEN]  = prev[ERR_LEN] | (s_axis.tlast & (meas_len != claim));
        pkt_err[ERR_OVS]  = prev[ERR_OVS] | (~s_axis.tlast & (cur_n == P_MAX_BEATS));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            n         <= '0;
            claimed   <= '0;
            perr      <= '0;
            pkt_done  <= 1'b0;
            pkt_ok    <= 1'b0;
            pkt_len   <= '0;
            pkt_cnt   <= '0;
            err_cnt   <= '0;
            err_flags <= '0;
        end else begin
            pkt_done <= acc & s_axis.tlast;
            if (acc) begin
                n       <= cur_n;
                claimed <= claim;
                perr    <= pkt_err;
            end
            if (acc & s_axis.tlast) begin
                pkt_ok    <= ~|pkt_err;
                pkt_len   <= meas_len;
                pkt_cnt   <= pkt_cnt + 32'd1;
                err_cnt   <= err_cnt + {31'd0, |pkt_err};
                err_flags <= err_flags | pkt_err;
            end
        end
    end
endmodule

// File: tb/tb_axis_test_checker.sv
// tb_axis_test_checker: vectors, random backpressure traffic and reset corner cases for axis_test_checker
module tb_axis_test_checker;
    typedef struct {
        int          nb;
        logic [7:0]  kp;
        logic [15:0] usr;
        int          bb;
        logic [63:0] bv;
        logic        ok;
        logic [15:0] len;
        logic [31:0] pc;
        logic [31:0] ec;
        logic [3:0]  fl;
    } vec_t;
    typedef struct {
        logic        ok;
        logic [15:0] len;
        logic [31:0] pc;
        logic [31:0] ec;
        logic [3:0]  fl;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [63:0] tdata = '0;
    logic [31:0] tuser = '0;
    logic [7:0]  tkeep = '0;
    logic        tlast = 1'b0;
    logic        tvalid = 1'b0;
    int          sel = 0;

    logic        rdy[3], done[3], ok[3];
    logic [15:0] len[3];
    logic [31:0] pc[3], ec[3];
    logic [3:0]  fl[3];

    axis_test_checker_if ifa ();
    axis_test_checker_if ifb ();
    axis_test_checker_if ifc ();
    assign ifa.tdata = tdata;
    assign ifa.tuser = tuser;
    assign ifa.tkeep = tkeep;
    assign ifa.tlast = tlast;
    assign ifa.tvalid = tvalid && sel == 0;
    assign ifb.tdata = tdata;
    assign ifb.tuser = tuser;
    assign ifb.tkeep = tkeep;
    assign ifb.tlast = tlast;
    assign ifb.tvalid = tvalid && sel == 1;
    assign ifc.tdata = tdata;
    assign ifc.tuser = tuser;
    assign ifc.tkeep = tkeep;
    assign ifc.tlast = tlast;
    assign ifc.tvalid = tvalid && sel == 2;
    assign rdy[0] = ifa.tready;
    assign rdy[1] = ifb.tready;
    assign rdy[2] = ifc.tready;

    axis_test_checker dut_a (
        .i_clk(clk), .i_rst(rst), .s_axis(ifa), .pkt_done(done[0]), .pkt_ok(ok[0]),
        .pkt_len(len[0]), .pkt_cnt(pc[0]), .err_cnt(ec[0]), .err_flags(fl[0])
    );
    axis_test_checker #(.P_BP_EN(1'b1)) dut_b (
        .i_clk(clk), .i_rst(rst), .s_axis(ifb), .pkt_done(done[1]), .pkt_ok(ok[1]),
        .pkt_len(len[1]), .pkt_cnt(pc[1]), .err_cnt(ec[1]), .err_flags(fl[1])
    );
    axis_test_checker #(.P_MAX_BEATS(16'd4)) dut_c (
        .i_clk(clk), .i_rst(rst), .s_axis(ifc), .pkt_done(done[2]), .pkt_ok(ok[2]),
        .pkt_len(len[2]), .pkt_cnt(pc[2]), .err_cnt(ec[2]), .err_flags(fl[2])
    );

    int total = 0;
    int bad = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, need %0h", nm, act, req);
        end
    endtask

    // reference model: whole packet judged at once from the recorded beats
    res_t        exp_q[$];
    res_t        e;
    logic [63:0] pd[$];
    logic [7:0]  pk[$];
    logic [15:0] pclaim = '0;
    logic [31:0] mpc[3] = '{0, 0, 0};
    logic [31:0] mec[3] = '{0, 0, 0};
    logic [3:0]  mfl[3] = '{0, 0, 0};
    int ndone = 0, rlo = 0, rhi = 0;

    function automatic res_t model(input int d);
        res_t r;
        int mx, nb, ns;
        logic [63:0] pat, msk;
        logic [7:0] lk;
        logic [3:0] f;
        logic leg;
        mx = d == 2 ? 4 : 1024;
        nb = pd.size();
        lk = pk[nb-1];
        f = '0;
        for (int i = 0; i < nb && i < mx; i++) begin
            pat = {4{16'(i + 1)}};
            msk = '0;
            for (int b = 0; b < 8; b++) if (i < nb - 1 || lk[b]) msk[8*b +: 8] = 8'hFF;
            if (((pd[i] ^ pat) & msk) != 64'd0) f[0] = 1'b1;
            if (i < nb - 1 && pk[i] != 8'hFF) f[1] = 1'b1;
        end
        if (nb <= mx) begin
            leg = 1'b0;
            for (int k = 0; k < 8; k++) if (lk == 8'(8'hFF << k)) leg = 1'b1;
            if (!leg) f[1] = 1'b1;
        end
        ns = nb < mx ? nb : mx;
        r.len = 16'(8 * (ns - 1) + $countones(lk));
        if (r.len != pclaim) f[2] = 1'b1;
        if (nb > mx) f[3] = 1'b1;
        mpc[d] = mpc[d] + 32'd1;
        if (f != 4'd0) mec[d] = mec[d] + 32'd1;
        mfl[d] = mfl[d] | f;
        r.ok = f == 4'd0;
        r.pc = mpc[d];
        r.ec = mec[d];
        r.fl = mfl[d];
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            pd.delete();
            pk.delete();
            exp_q.delete();
            for (int d = 0; d < 3; d++) begin
                mpc[d] = '0;
                mec[d] = '0;
                mfl[d] = '0;
            end
        end else begin
            if (sel == 1) begin
                if (rdy[1]) rhi++;
                else rlo++;
            end
            if (done[sel]) begin
                ndone++;
                if (exp_q.size() == 0) chk("unexpected_done", 32'(done[sel]), 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("mdl_ok", 32'(ok[sel]), 32'(e.ok));
                    chk("mdl_len", 32'(len[sel]), 32'(e.len));
                    chk("mdl_pkt_cnt", pc[sel], e.pc);
                    chk("mdl_err_cnt", ec[sel], e.ec);
                    chk("mdl_flags", 32'(fl[sel]), 32'(e.fl));
                end
            end
            if (tvalid && rdy[sel]) begin
                if (pd.size() == 0) pclaim = tuser[15:0];
                pd.push_back(tdata);
                pk.push_back(tkeep);
                if (tlast) begin
                    exp_q.push_back(model(sel));
                    pd.delete();
                    pk.delete();
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic [15:0] u);
        int t = 0;
        tdata = d;
        tkeep = k;
        tlast = l;
        tuser = {16'($urandom), u};
        tvalid = 1'b1;
        @(negedge clk);
        while (!rdy[sel] && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (!rdy[sel]) chk("ready_timeout", 32'(t), 32'd0);
        sync();
        tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int nb, input logic [7:0] lk, input logic [15:0] u,
                            input int bb, input logic [63:0] bv, input bit gaps);
        logic [63:0] d;
        for (int n = 1; n <= nb; n++) begin
            d = {4{16'(n)}};
            if (n == nb) for (int b = 0; b < 8; b++) if (!lk[b]) d[8*b +: 8] = 8'($urandom);
            if (n == bb) d = bv;
            send_beat(d, n == nb ? lk : 8'hFF, n == nb, n == 1 ? u : 16'($urandom));
            if (gaps && n < nb) repeat ($urandom_range(0, 2)) sync();
        end
    endtask

    task automatic wait_done(input string nm);
        int t = 0;
        @(negedge clk);
        while (!done[sel] && t < 50) begin
            t++;
            @(negedge clk);
        end
        chk(nm, 32'(done[sel]), 32'd1);
    endtask

    vec_t tbl[16];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, n0, nb, k;
        logic [7:0] lk;
        tbl[0]  = '{16, 8'h80, 16'd121, 0, 64'd0, 1'b1, 16'd121, 32'd1, 32'd0, 4'h0};
        tbl[1]  = '{16, 8'hC0, 16'd122, 0, 64'd0, 1'b1, 16'd122, 32'd2, 32'd0, 4'h0};
        tbl[2]  = '{16, 8'hE0, 16'd123, 0, 64'd0, 1'b1, 16'd123, 32'd3, 32'd0, 4'h0};
        tbl[3]  = '{16, 8'hF0, 16'd124, 0, 64'd0, 1'b1, 16'd124, 32'd4, 32'd0, 4'h0};
        tbl[4]  = '{16, 8'hF8, 16'd125, 0, 64'd0, 1'b1, 16'd125, 32'd5, 32'd0, 4'h0};
        tbl[5]  = '{16, 8'hFC, 16'd126, 0, 64'd0, 1'b1, 16'd126, 32'd6, 32'd0, 4'h0};
        tbl[6]  = '{16, 8'hFE, 16'd127, 0, 64'd0, 1'b1, 16'd127, 32'd7, 32'd0, 4'h0};
        tbl[7]  = '{16, 8'hFF, 16'd128, 0, 64'd0, 1'b1, 16'd128, 32'd8, 32'd0, 4'h0};
        tbl[8]  = '{16, 8'hFF, 16'd128, 5, 64'h0005_0005_0005_0006, 1'b0, 16'd128, 32'd9, 32'd1, 4'h1};
        tbl[9]  = '{16, 8'h0F, 16'd124, 0, 64'd0, 1'b0, 16'd124, 32'd10, 32'd2, 4'h3};
        tbl[10] = '{16, 8'hFF, 16'd100, 0, 64'd0, 1'b0, 16'd128, 32'd11, 32'd3, 4'h7};
        tbl[11] = '{1, 8'hFF, 16'd8, 0, 64'd0, 1'b1, 16'd8, 32'd12, 32'd3, 4'h7};
        tbl[12] = '{1, 8'h80, 16'd1, 0, 64'd0, 1'b1, 16'd1, 32'd13, 32'd3, 4'h7};
        tbl[13] = '{3, 8'hFE, 16'd23, 0, 64'd0, 1'b1, 16'd23, 32'd14, 32'd3, 4'h7};
        tbl[14] = '{2, 8'hC0, 16'd10, 2, 64'h0002_1111_1111_1111, 1'b1, 16'd10, 32'd15, 32'd3, 4'h7};
        tbl[15] = '{2, 8'hC0, 16'd10, 2, 64'h0003_0002_0002_0002, 1'b0, 16'd10, 32'd16, 32'd4, 4'h7};
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_done", 32'(done[0]), 32'd0);
        chk("rst_ok", 32'(ok[0]), 32'd0);
        chk("rst_len", 32'(len[0]), 32'd0);
        chk("rst_pkt_cnt", pc[0], 32'd0);
        chk("rst_err_cnt", ec[0], 32'd0);
        chk("rst_flags", 32'(fl[0]), 32'd0);
        chk("rst_ready_a", 32'(rdy[0]), 32'd0);
        chk("rst_ready_b", 32'(rdy[1]), 32'd0);
        sync();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_reset", 32'(rdy[0]), 32'd1);
        sync();
        sel = 0;
        for (int i = 0; i < 16; i++) begin
            send_pkt(tbl[i].nb, tbl[i].kp, tbl[i].usr, tbl[i].bb, tbl[i].bv, 1'b0);
            wait_done($sformatf("tbl%0d_done", i));
            chk($sformatf("tbl%0d_ok", i), 32'(ok[0]), 32'(tbl[i].ok));
            chk($sformatf("tbl%0d_len", i), 32'(len[0]), 32'(tbl[i].len));
            chk($sformatf("tbl%0d_pkt_cnt", i), pc[0], tbl[i].pc);
            chk($sformatf("tbl%0d_err_cnt", i), ec[0], tbl[i].ec);
            chk($sformatf("tbl%0d_flags", i), 32'(fl[0]), 32'(tbl[i].fl));
            sync();
        end
        c0 = cyc;
        n0 = ndone;
        for (int i = 0; i < 5; i++) send_pkt(1, 8'hFF, 16'd8, 0, 64'd0, 1'b0);
        chk("b2b_cycles", 32'(cyc - c0), 32'd5);
        repeat (3) @(negedge clk);
        chk("b2b_done_count", 32'(ndone - n0), 32'd5);
        chk("b2b_pkt_cnt", pc[0], 32'd21);
        sync();
        sel = 1;
        for (int p = 0; p < 100; p++) begin
            nb = $urandom_range(1, 20);
            k = $urandom_range(0, 7);
            lk = 8'hFF << k;
            send_pkt(nb, lk, 16'(8 * (nb - 1) + 8 - k), 0, 64'd0, 1'b1);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) sync();
        end
        repeat (5) @(negedge clk);
        chk("bp_pkt_cnt", pc[1], 32'd100);
        chk("bp_err_cnt", ec[1], 32'd0);
        chk("bp_ready_low_seen", 32'(rlo > 0), 32'd1);
        chk("bp_ready_high_seen", 32'(rhi > 0), 32'd1);
        chk("bp_drain", 32'(exp_q.size()), 32'd0);
        sync();
        sel = 2;
        send_pkt(6, 8'hFF, 16'd32, 5, 64'hDEAD_BEEF_0BAD_F00D, 1'b0);
        wait_done("ovs_done");
        chk("ovs_ok", 32'(ok[2]), 32'd0);
        chk("ovs_flags", 32'(fl[2]), 32'h8);
        chk("ovs_len", 32'(len[2]), 32'd32);
        chk("ovs_err_cnt", ec[2], 32'd1);
        sync();
        send_pkt(4, 8'hF0, 16'd28, 0, 64'd0, 1'b0);
        wait_done("max_done");
        chk("max_ok", 32'(ok[2]), 32'd1);
        chk("max_flags", 32'(fl[2]), 32'h8);
        chk("max_pkt_cnt", pc[2], 32'd2);
        sync();
        send_beat({4{16'd1}}, 8'hFF, 1'b0, 16'd24);
        send_beat({4{16'd2}}, 8'hFF, 1'b0, 16'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 32'(rdy[2]), 32'd0);
        chk("mid_rst_done", 32'(done[2]), 32'd0);
        chk("mid_rst_ok", 32'(ok[2]), 32'd0);
        chk("mid_rst_len", 32'(len[2]), 32'd0);
        chk("mid_rst_pkt_cnt", pc[2], 32'd0);
        chk("mid_rst_err_cnt", ec[2], 32'd0);
        chk("mid_rst_flags", 32'(fl[2]), 32'd0);
        chk("mid_rst_pkt_cnt_a", pc[0], 32'd0);
        sync();
        rst = 1'b0;
        sync();
        send_pkt(2, 8'hFF, 16'd16, 0, 64'd0, 1'b0);
        wait_done("post_rst_done");
        chk("post_rst_ok", 32'(ok[2]), 32'd1);
        chk("post_rst_len", 32'(len[2]), 32'd16);
        chk("post_rst_pkt_cnt", pc[2], 32'd1);
        chk("post_rst_flags", 32'(fl[2]), 32'd0);
        repeat (3) @(negedge clk);
        chk("final_drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axis_test_checker.md
# axis_test_checker

Receive-side counterpart of the AXIS test traffic generator. It sinks 64-bit AXI-Stream test packets and checks each one: incrementing data pattern, MSB-aligned last-beat tkeep, and byte length claimed in tuser. It publishes per-packet results and sticky statistics. It sits at the far end of the 10G loopback path, MAC RX user side, and can optionally apply pseudo-random backpressure.

## Interface
Parameters:
- P_MAX_BEATS, 16'd1024: beats per packet before an oversize error is declared.
- P_BP_EN, 1'b0: 1 drives tready from the LFSR; 0 holds tready high.
- P_LFSR_SEED, 8'hA5: LFSR reset value; must be nonzero.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- s_axis_tdata  in  64  packet data
- s_axis_tuser  in  32  [15:0] claimed byte length; [31:16] ignored
- s_axis_tkeep  in  8  byte enables, MSB-aligned
- s_axis_tlast  in  1  last beat of packet
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  beat accept
- o_pkt_done  out  1  one-cycle pulse, packet result valid
- o_pkt_ok  out  1  qualified by o_pkt_done; 1 when no error
- o_pkt_len  out  16  measured byte count of the packet
- o_pkt_cnt  out  32  total packets received
- o_err_cnt  out  32  total packets with any error
- o_err_flags  out  4  sticky: [0] data, [1] keep, [2] length, [3] oversize

## Operation
- A beat is accepted when s_axis_tvalid & s_axis_tready. Nothing changes on non-accepted cycles.
- FSM states:
  - S_FIRST waits for beat 1. On accept it latches tuser[15:0] as claimed length, sets beat index n=1, and goes to S_BODY. If tlast is set on beat 1, it completes the packet and stays in S_FIRST.
  - S_BODY checks each accepted beat. When tlast is accepted, it completes the packet and returns to S_FIRST.
- Data check: beat n (1-based, 16-bit) must equal {4{n}}. On the last beat, only bytes with tkeep=1 are compared; byte i maps to tdata[8i+7:8i]. A mismatch sets the packet's data error.
- Keep check:
  - Non-last beats must have tkeep=8'hFF.
  - The last beat must be one of FF, FE, FC, F8, F0, E0, C0, 80.
  - Any other value sets the keep error. For length, popcount(tkeep) is still used.
- Length: measured = 8*(n_last-1) + popcount(last tkeep), mod 2^16. If it differs from the claimed length, the length error is set.
- Oversize: if n would exceed P_MAX_BEATS without tlast, the oversize error is set. After that, data and keep checks are suppressed, beats are still accepted until tlast, and n saturates at P_MAX_BEATS.
- On completion:
  - o_pkt_cnt increments by 1.
  - o_err_cnt increments by 1 if any per-packet error is set.
  - The per-packet error bits are OR-ed into o_err_flags.
  - Both counters wrap at 2^32.
- Backpressure:
  - P_BP_EN=1: an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) advances every cycle, and s_axis_tready = lfsr[0].
  - P_BP_EN=0: s_axis_tready = 1.
  - tready is a register output and never depends combinationally on tvalid.

## Timing
- Reset values:
  - s_axis_tready 0; o_pkt_done 0; o_pkt_ok 0; o_pkt_len 0.
  - o_pkt_cnt 0; o_err_cnt 0; o_err_flags 0.
  - FSM S_FIRST; LFSR P_LFSR_SEED.
- First cycle after reset release: tready is 1 (P_BP_EN=0) or the LFSR bit.
- Latency: o_pkt_done, o_pkt_ok, o_pkt_len, the counters and o_err_flags all update on the cycle after the accepted tlast beat.
- Back-to-back packets: beat 1 of the next packet may be accepted on the same cycle o_pkt_done is high. Throughput is one beat per cycle.
- Reset mid-packet:
  - The in-flight packet is discarded with no result.
  - Counters clear.
  - The next accepted beat is treated as beat 1.

## Structure
- Shared package axis_test_pkg holds:
  - error bit indices ERR_DATA=0, ERR_KEEP=1, ERR_LEN=2, ERR_OVS=3;
  - the beat pattern width (16);
  - the legal last-keep set.
- The generator and checker share this package.
- One sub-module, axis_ready_lfsr, contains the LFSR plus the tready register. Parameters: P_BP_EN, P_LFSR_SEED.

## Test plan
- Good packet, P_BP_EN=0:
  - Stimulus: 16 beats {4{n}}, n=1..16; last tkeep=80; tuser=121.
  - Required: o_pkt_done with ok=1, len=121, pkt_cnt=1, err_cnt=0.
- Sweep of eight packets:
  - Stimulus: last tkeep 80,C0,…,FF with tuser 121..128.
  - Required: all ok; o_pkt_len 121..128; pkt_cnt=8.
- Corrupt data: beat 5 = 64'h0005_0005_0005_0006.
  - Required: ok=0; o_err_flags=4'b0001; err_cnt=1.
- Bad keep and bad length:
  - Last tkeep=8'h0F: keep error bit set.
  - tuser=100 with 16 beats, tkeep=FF: length error bit set, len=128.
- P_BP_EN=1:
  - Stimulus: 100 random good packets.
  - Required: tready toggles; no beat dropped or duplicated; pkt_cnt=100; err_cnt=0.
- Oversize and reset:
  - Stimulus: P_MAX_BEATS=4 with a 6-beat packet; then i_rst mid-packet.
  - Required: flags=4'b1000 for the oversize packet. After the reset, all outputs return to reset values and the next packet passes.
